// File: rtl/calc_entry_ctrl_pkg.sv
// Shared constants for the calculator entry sequencer: key codes, operator and
// state encodings, and the decimal limit derived from the digit count.
package calc_pkg;

  localparam int unsigned CALC_DIGITS  = 4;
  localparam int unsigned CALC_TIMEOUT = 255;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Smallest value that no longer fits in CALC_DIGITS decimal digits.
  localparam int unsigned CALC_LIMIT = pow10(CALC_DIGITS);
  localparam int unsigned CALC_W     = $clog2(CALC_LIMIT);

  localparam logic [4:0] NO_KEY    = 5'd17;
  localparam logic [4:0] KEY_LAST  = 5'd15;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_DIV   = 4'd13;
  localparam logic [3:0] KEY_EQ    = 4'd14;
  localparam logic [3:0] KEY_CLR   = 4'd15;

  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

  typedef enum logic [2:0] {S_A, S_B, S_REQ, S_RES, S_ERR} state_t;

  function automatic op_t key_to_op(input logic [3:0] k);
    case (k)
      KEY_ADD: return OP_ADD;
      KEY_SUB: return OP_SUB;
      KEY_MUL: return OP_MUL;
      default: return OP_DIV;
    endcase
  endfunction

endpackage

// File: rtl/calc_entry_ctrl_if.sv
// Controller-to-ALU transaction bus.
// Handshake: calc_req rises with stable operands/op and stays high until a
// one-cycle calc_ack pulse; calc_result/calc_err are valid only with calc_ack.
interface calc_alu_if #(parameter int unsigned W = 14) ();
  logic         calc_req;
  logic         calc_ack;
  logic [1:0]   calc_op;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [W-1:0] calc_result;
  logic         calc_err;

  modport master (
    output calc_req, calc_op, operand_a, operand_b,
    input  calc_ack, calc_result, calc_err
  );

  modport slave (
    input  calc_req, calc_op, operand_a, operand_b,
    output calc_ack, calc_result, calc_err
  );
endinterface

// File: rtl/calc_entry_ctrl_key_event_detect.sv
// Turns the scanner's level key code into a one-cycle press event plus a
// classification of the current key.
module key_event_detect
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key_code_i,
  output logic       press_o,
  output logic       is_digit_o,
  output logic       is_op_o,
  output logic       is_eq_o,
  output logic       is_clr_o,
  output logic [3:0] key_val_o
);

  logic [4:0] prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= NO_KEY;
    else        prev_q <= key_code_i;
  end

  // A direct change between two valid codes is a new press.
  assign press_o    = (key_code_i <= KEY_LAST) && (key_code_i != prev_q);
  assign key_val_o  = key_code_i[3:0];
  assign is_digit_o = key_val_o <= DIGIT_MAX;
  assign is_op_o    = (key_val_o >= KEY_ADD) && (key_val_o <= KEY_DIV);
  assign is_eq_o    = key_val_o == KEY_EQ;
  assign is_clr_o   = key_val_o == KEY_CLR;

endmodule

// File: rtl/calc_entry_ctrl.sv
// Calculator entry sequencer: accumulates two decimal operands and an operator
// from key presses, runs one ALU transaction on '=', then shows result or error.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS  = CALC_DIGITS,
  parameter int unsigned W       = CALC_W,
  parameter int unsigned TIMEOUT = CALC_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [4:0]   key_code,
  calc_alu_if.master   alu,
  output logic [W-1:0] disp_value,
  output logic         err_flag,
  output logic         busy,
  output state_t       dbg_state_o
);

  localparam int unsigned CW    = $clog2(DIGITS + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);
  localparam logic [31:0] LIMIT = 32'(pow10(DIGITS));

  logic       press, is_digit, is_op, is_eq, is_clr;
  logic [3:0] key_val;

  key_event_detect u_key (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code_i (key_code),
    .press_o    (press),
    .is_digit_o (is_digit),
    .is_op_o    (is_op),
    .is_eq_o    (is_eq),
    .is_clr_o   (is_clr),
    .key_val_o  (key_val)
  );

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, disp_q, disp_d;
  op_t             op_q, op_d;
  logic [CW-1:0]   acnt_q, acnt_d, bcnt_q, bcnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            req_q, req_d, busy_q, busy_d, err_q, err_d;
  logic [W-1:0]    a_acc, b_acc;

  assign a_acc = a_q * W'(10) + W'(key_val);
  assign b_acc = b_q * W'(10) + W'(key_val);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    op_d    = op_q;
    acnt_d  = acnt_q;
    bcnt_d  = bcnt_q;
    tmo_d   = tmo_q;

    if (press && is_clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      res_d   = '0;
      op_d    = OP_ADD;
      acnt_d  = '0;
      bcnt_d  = '0;
      tmo_d   = '0;
    end else begin
      case (state_q)
        S_A: if (press) begin
          if (is_digit) begin
            if (acnt_q < CW'(DIGITS)) begin
              a_d    = a_acc;
              acnt_d = acnt_q + 1'b1;
            end
          end else if (is_op) begin
            op_d    = key_to_op(key_val);
            b_d     = '0;
            bcnt_d  = '0;
            state_d = S_B;
          end
        end
        S_B: if (press) begin
          if (is_digit) begin
            if (bcnt_q < CW'(DIGITS)) begin
              b_d    = b_acc;
              bcnt_d = bcnt_q + 1'b1;
            end
          end else if (is_op) begin
            if (bcnt_q == '0) op_d = key_to_op(key_val);
          end else if (is_eq && bcnt_q != '0) begin
            tmo_d   = '0;
            state_d = S_REQ;
          end
        end
        S_REQ: begin
          // An ack arriving on the last timeout cycle still wins.
          if (alu.calc_ack) begin
            if (alu.calc_err) begin
              state_d = S_ERR;
            end else begin
              res_d   = alu.calc_result;
              state_d = S_RES;
            end
          end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = S_ERR;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        S_RES: if (press) begin
          if (is_digit) begin
            a_d     = W'(key_val);
            acnt_d  = CW'(1);
            state_d = S_A;
          end else if (is_op) begin
            if (32'(res_q) >= LIMIT) begin
              state_d = S_ERR;
            end else begin
              a_d     = res_q;
              op_d    = key_to_op(key_val);
              b_d     = '0;
              bcnt_d  = '0;
              state_d = S_B;
            end
          end
        end
        S_ERR: ;
        default: state_d = S_A;
      endcase
    end

    req_d  = state_d == S_REQ;
    busy_d = state_d == S_REQ;
    err_d  = state_d == S_ERR;
    case (state_d)
      S_A:     disp_d = a_d;
      S_B:     disp_d = (bcnt_d != '0) ? b_d : a_d;
      S_REQ:   disp_d = b_d;
      S_RES:   disp_d = res_d;
      default: disp_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      op_q    <= OP_ADD;
      acnt_q  <= '0;
      bcnt_q  <= '0;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      op_q    <= op_d;
      acnt_q  <= acnt_d;
      bcnt_q  <= bcnt_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
    end
  end

  assign alu.calc_req  = req_q;
  assign alu.calc_op   = op_q;
  assign alu.operand_a = a_q;
  assign alu.operand_b = b_q;
  assign disp_value    = disp_q;
  assign err_flag      = err_q;
  assign busy          = busy_q;
  assign dbg_state_o   = state_q;

endmodule
